// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetches win every slot, the CPU fills the idle ones.
// Define VRAM_STARVE_GUARD_EN to force a CPU grant after MAX_WAIT blocked cycles.
module vga_vram_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_drop,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {OWN_DISP = 1'b0, OWN_CPU = 1'b1} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic       starve_en;
  logic       starve;
  logic       force_gnt;
  logic       cpu_xfer;
  logic       disp_issue;
  logic [7:0] wait_q;
  tag_t       tag_in;
  tag_t       tag_q [RD_LAT+1];

`ifdef VRAM_STARVE_GUARD_EN
  assign starve_en = 1'b1;
`else
  assign starve_en = 1'b0;
`endif

  assign starve     = (wait_q >= WAIT_LIM);
  assign force_gnt  = starve_en & cpu_req & starve;
  assign cpu_gnt    = ~Reset & (~disp_req | force_gnt);
  assign cpu_xfer   = cpu_req & cpu_gnt;
  // A forced CPU grant steals the slot, so the display request is dropped.
  assign disp_issue = disp_req & ~force_gnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_q <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      wait_q <= '0;
    end else if (wait_q != '1) begin
      wait_q <= wait_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_en    <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      disp_drop <= '0;
    end else begin
      disp_drop <= disp_req & force_gnt;
      if (disp_issue) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end else if (cpu_xfer) begin
        mem_en    <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

  always_comb begin
    tag_in.valid = disp_issue | (cpu_xfer & ~cpu_we);
    tag_in.owner = disp_issue ? OWN_DISP : OWN_CPU;
  end

  // Stage 0 rides alongside the mem_* issue; stage RD_LAT lines up with mem_rdata.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp_rvalid <= '0;
      disp_rdata  <= '0;
      cpu_rvalid  <= '0;
      cpu_rdata   <= '0;
    end else begin
      disp_rvalid <= tag_q[RD_LAT].valid && (tag_q[RD_LAT].owner == OWN_DISP);
      cpu_rvalid  <= tag_q[RD_LAT].valid && (tag_q[RD_LAT].owner == OWN_CPU);
      if (tag_q[RD_LAT].valid && (tag_q[RD_LAT].owner == OWN_DISP)) begin
        disp_rdata <= mem_rdata;
      end
      if (tag_q[RD_LAT].valid && (tag_q[RD_LAT].owner == OWN_CPU)) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: one RD_LAT=1 and one RD_LAT=3 instance on shared inputs,
// each backed by a write-first VRAM model preloaded with (addr[7:0] ^ 0x5A).
module tb_vga_vram_arbiter;

  logic        Clk;
  logic        Reset;
  logic        disp_req;
  logic [16:0] disp_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        disp_rvalid1, disp_drop1, cpu_gnt1, cpu_rvalid1, mem_en1, mem_we1;
  logic [7:0]  disp_rdata1, cpu_rdata1, mem_wdata1, mem_rdata1;
  logic [16:0] mem_addr1;
  logic        disp_rvalid3, disp_drop3, cpu_gnt3, cpu_rvalid3, mem_en3, mem_we3;
  logic [7:0]  disp_rdata3, cpu_rdata3, mem_wdata3, mem_rdata3;
  logic [16:0] mem_addr3;

  int checks   = 0;
  int failures = 0;
  logic [7:0] ed;

  vga_vram_arbiter #(.ADDR_W(17), .DATA_W(8), .RD_LAT(1), .MAX_WAIT(15)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid1), .disp_rdata(disp_rdata1), .disp_drop(disp_drop1),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  vga_vram_arbiter #(.ADDR_W(17), .DATA_W(8), .RD_LAT(3), .MAX_WAIT(15)) u_dut3 (
    .Clk(Clk), .Reset(Reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid3), .disp_rdata(disp_rdata3), .disp_drop(disp_drop3),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // VRAM models: written words override the preload pattern.
  logic       wv1 [1024];
  logic [7:0] wd1 [1024];
  logic       wv3 [1024];
  logic [7:0] wd3 [1024];
  logic [7:0] p3_0, p3_1, p3_2;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 1024; i++) wv1[i] <= 1'b0;
    end else if (mem_en1 && mem_we1) begin
      wv1[mem_addr1[9:0]] <= 1'b1;
      wd1[mem_addr1[9:0]] <= mem_wdata1;
    end
    if (mem_en1 && !mem_we1)
      mem_rdata1 <= wv1[mem_addr1[9:0]] ? wd1[mem_addr1[9:0]] : (mem_addr1[7:0] ^ 8'h5A);
  end

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 1024; i++) wv3[i] <= 1'b0;
    end else if (mem_en3 && mem_we3) begin
      wv3[mem_addr3[9:0]] <= 1'b1;
      wd3[mem_addr3[9:0]] <= mem_wdata3;
    end
    if (mem_en3 && !mem_we3)
      p3_0 <= wv3[mem_addr3[9:0]] ? wd3[mem_addr3[9:0]] : (mem_addr3[7:0] ^ 8'h5A);
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign mem_rdata3 = p3_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; disp_req = 1'b1; disp_addr = 17'h5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h10; cpu_wdata = 8'h00;
    mem_rdata1 = 8'h00; p3_0 = 8'h00; p3_1 = 8'h00; p3_2 = 8'h00;

    // Reset held 3 cycles with both requests asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt1", cpu_gnt1, 1'b0);
      check("rst_gnt3", cpu_gnt3, 1'b0);
      check("rst_mem_en1", mem_en1, 1'b0);
      check("rst_mem_en3", mem_en3, 1'b0);
    end
    check("rst_mem_we1", mem_we1, 1'b0);
    check("rst_mem_addr1", mem_addr1, 17'h0);
    check("rst_mem_wdata1", mem_wdata1, 8'h0);
    check("rst_disp_rvalid1", disp_rvalid1, 1'b0);
    check("rst_disp_rdata1", disp_rdata1, 8'h0);
    check("rst_cpu_rvalid1", cpu_rvalid1, 1'b0);
    check("rst_cpu_rdata1", cpu_rdata1, 8'h0);
    check("rst_disp_drop1", disp_drop1, 1'b0);
    check("rst_out3", {mem_we3, mem_addr3, mem_wdata3, disp_rvalid3, disp_rdata3,
                       cpu_rvalid3, cpu_rdata3, disp_drop3}, 32'h0);

    Reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
    tick();

    // CPU write 0x10 = 0xA5, then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h10; cpu_wdata = 8'hA5;
    #1 check("wr_gnt", cpu_gnt1, 1'b1);
    tick();
    check("wr_mem_en", mem_en1, 1'b1);
    check("wr_mem_we", mem_we1, 1'b1);
    check("wr_mem_addr", mem_addr1, 17'h10);
    check("wr_mem_wdata", mem_wdata1, 8'hA5);
    cpu_we = 1'b0; cpu_wdata = 8'h00;
    #1 check("rd_gnt", cpu_gnt1, 1'b1);
    tick();
    check("rd_mem_en", mem_en1, 1'b1);
    check("rd_mem_we", mem_we1, 1'b0);
    check("rd_wdata_hold", mem_wdata1, 8'h00);
    cpu_req = 1'b0;
    tick();
    check("rd_early_rvalid", cpu_rvalid1, 1'b0);
    check("idle_mem_en", mem_en1, 1'b0);
    check("idle_addr_hold", mem_addr1, 17'h10);
    tick();
    check("rd_rvalid", cpu_rvalid1, 1'b1);
    check("rd_rdata", cpu_rdata1, 8'hA5);
    check("rd_no_disp", disp_rvalid1, 1'b0);
    tick();
    check("rd_rvalid_pulse", cpu_rvalid1, 1'b0);
    check("rd_rdata_hold", cpu_rdata1, 8'hA5);

    // Conflict: display (0x020) and CPU read (0x100) in the same cycle
    disp_req = 1'b1; disp_addr = 17'h20;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h100;
    #1 check("cf_gnt_blocked", cpu_gnt1, 1'b0);
    tick();
    check("cf_disp_issue_en", mem_en1, 1'b1);
    check("cf_disp_issue_addr", mem_addr1, 17'h20);
    check("cf_no_drop", disp_drop1, 1'b0);
    disp_req = 1'b0;
    #1 check("cf_gnt_free", cpu_gnt1, 1'b1);
    tick();
    check("cf_cpu_issue_addr", mem_addr1, 17'h100);
    check("cf_cpu_issue_we", mem_we1, 1'b0);
    cpu_req = 1'b0;
    tick();
    check("cf_disp_rvalid", disp_rvalid1, 1'b1);
    check("cf_disp_rdata", disp_rdata1, 8'h7A);
    check("cf_cpu_not_yet", cpu_rvalid1, 1'b0);
    tick();
    check("cf_cpu_rvalid", cpu_rvalid1, 1'b1);
    check("cf_cpu_rdata", cpu_rdata1, 8'h5A);
    check("cf_disp_done", disp_rvalid1, 1'b0);
    check("cf_disp_rdata_hold", disp_rdata1, 8'h7A);
    tick();

    // Alternating display/CPU reads on the RD_LAT=3 instance (latency 5)
    for (int i = 0; i < 25; i++) begin
      disp_req  = (i < 20) && (i % 2 == 0);
      disp_addr = 17'(32'h40 + i);
      cpu_req   = (i < 20) && (i % 2 == 1);
      cpu_we    = 1'b0;
      cpu_addr  = 17'(32'h80 + i);
      #1;
      if (i % 2 == 1 && i < 20) check("alt_gnt", cpu_gnt3, 1'b1);
      if (i >= 1 && i <= 20) begin
        check("alt_mem_en", mem_en3, 1'b1);
        check("alt_mem_addr", mem_addr3,
              ((i - 1) % 2 == 0) ? 17'(32'h40 + i - 1) : 17'(32'h80 + i - 1));
      end
      if (i >= 5) begin
        if ((i - 5) % 2 == 0) begin
          ed = 8'(32'h40 + i - 5) ^ 8'h5A;
          check("alt_disp_rvalid", disp_rvalid3, 1'b1);
          check("alt_disp_rdata", disp_rdata3, ed);
          check("alt_disp_no_cpu", cpu_rvalid3, 1'b0);
        end else begin
          ed = 8'(32'h80 + i - 5) ^ 8'h5A;
          check("alt_cpu_rvalid", cpu_rvalid3, 1'b1);
          check("alt_cpu_rdata", cpu_rdata3, ed);
          check("alt_cpu_no_disp", disp_rvalid3, 1'b0);
        end
      end
      if (i < 20) check("alt_no_drop", disp_drop3, 1'b0);
      tick();
    end

    // Reset one cycle after a CPU read issue discards the return
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h30; disp_req = 1'b0;
    tick();
    check("rm_issue", mem_en1, 1'b1);
    cpu_req = 1'b0;
    tick();
    Reset = 1'b1; cpu_req = 1'b1; cpu_addr = 17'h31;
    #1 check("rm_gnt_in_reset", cpu_gnt1, 1'b0);
    tick();
    Reset = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rm_no_rvalid1", cpu_rvalid1, 1'b0);
      check("rm_no_rvalid3", cpu_rvalid3, 1'b0);
      check("rm_no_disp3", disp_rvalid3, 1'b0);
      tick();
    end

    // Continuous scanout against a waiting CPU
    for (int k = 0; k < 34; k++) begin
      disp_req = 1'b1; disp_addr = 17'h60;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h55;
      #1;
`ifdef VRAM_STARVE_GUARD_EN
      check("sg_gnt", cpu_gnt1, (k == 15) || (k == 31));
      check("sg_drop", disp_drop1, (k == 16) || (k == 32));
      if (k == 16 || k == 32) check("sg_forced_addr", mem_addr1, 17'h55);
      else if (k > 0) check("sg_disp_addr", mem_addr1, 17'h60);
`else
      check("strict_gnt", cpu_gnt1, 1'b0);
      check("strict_drop", disp_drop1, 1'b0);
      if (k > 0) check("strict_disp_addr", mem_addr1, 17'h60);
`endif
      tick();
    end

    disp_req = 1'b0; cpu_req = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port video RAM between two requesters.
- Requester 1 is the VGA scanout pixel fetcher: deadline-critical, highest priority, no backpressure.
- Requester 2 is the game/CPU side: reads and writes through a valid/ready handshake, granted only in cycles the scanout leaves free.
- Sits between the 640x480 timing/pixel pipeline, the CPU bus and the VRAM macro. Tags each access so read data returns to the requester that issued it.

Parameters:
- ADDR_W, 17, VRAM word-address width.
- DATA_W, 8, VRAM data width.
- RD_LAT, 1, VRAM read latency in Clk cycles from mem_* issue to mem_rdata valid; legal values 1..4.
- MAX_WAIT, 15, CPU wait-cycle limit used by the optional starvation guard; legal values 1..255.

Ports:
- Clk  in  1  system clock; all logic rising-edge.
- Reset  in  1  synchronous, active-high.
- disp_req  in  1  scanout fetch request; valid for one cycle, never held.
- disp_addr  in  ADDR_W  scanout fetch address.
- disp_rvalid  out  1  scanout read data valid.
- disp_rdata  out  DATA_W  scanout read data.
- disp_drop  out  1  pulse: a scanout request was not serviced (guard only).
- cpu_req  in  1  CPU request valid; held with address/data stable until accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  ready; a transfer occurs on a rising edge with cpu_req & cpu_gnt.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- mem_en  out  1  VRAM access enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid RD_LAT cycles after mem_en with mem_we=0.

Behaviour:
- Reset:
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, disp_rvalid, disp_rdata, cpu_rvalid, cpu_rdata, disp_drop.
  - Tag pipeline cleared; wait counter cleared.
  - Reset mid-operation discards in-flight reads; no rvalid is issued for them.
  - cpu_gnt is 0 while Reset is high.
- Grant is combinational and made each cycle:
  - cpu_gnt = ~Reset & ~disp_req (guard disabled).
  - Display wins every conflict; with disp_req=0 the CPU gets the slot.
- Issue, registered, one cycle after the winning request:
  - disp_req: mem_en=1, mem_we=0, mem_addr=disp_addr.
  - CPU transfer: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - Neither: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- Tag pipeline, RD_LAT+1 stages deep, each stage holding {valid, owner}:
  - Pushed for every read issue; writes push valid=0.
  - On exit, routes registered mem_rdata to disp_rdata/disp_rvalid or cpu_rdata/cpu_rvalid.
  - Total request-to-rvalid latency = RD_LAT+2 cycles for both requesters, fixed. Example: RD_LAT=1 gives 3 cycles.
  - rdata outputs hold their last value when rvalid=0.
- Back-to-back: one access per cycle sustained. A CPU read and a display read may be in flight together; returns stay in issue order.
- Same address, write then read in consecutive cycles: the read returns the new data. This requires a write-first VRAM; the block adds no forwarding.
- Write completion: the CPU write is complete at acceptance. No write acknowledge exists.
- Wait counter, 8 bits:
  - Increments each cycle cpu_req=1 & cpu_gnt=0.
  - Clears on a CPU transfer or when cpu_req=0.
  - Saturates at 255.
- Scanout: disp_drop stays 0 when the guard is disabled.

Optional Feature:
- Macro: VRAM_STARVE_GUARD_EN.
- Defined:
  - When wait counter >= MAX_WAIT and cpu_req=1, the CPU is granted that cycle even if disp_req=1 (cpu_gnt=1).
  - The display request is discarded; disp_drop pulses 1 in the issue cycle.
  - The counter clears. At most one forced grant per MAX_WAIT+1 cycles.
- Undefined:
  - Strict display priority; disp_drop is tied 0. The CPU may wait indefinitely during continuous scanout.

Test Plan:
- Reset held 3 cycles while cpu_req=1, disp_req=1 -> all outputs 0, cpu_gnt=0, no mem_en during Reset.
- CPU write 0x00010=0xA5 with disp idle, then CPU read 0x00010 (RD_LAT=1) -> mem_we=1 one cycle after accept; cpu_rvalid=1 with cpu_rdata=0xA5 three cycles after read accept.
- disp_req on the same cycle as a pending cpu_req (addr 0x00100) -> cpu_gnt=0 that cycle; display issues first; CPU issues the following cycle once disp_req=0; each rvalid routes to the correct owner.
- Alternating disp/CPU reads for 20 cycles, RD_LAT=3 -> one mem_en every cycle; returns in issue order; no rvalid cross-routing.
- Reset asserted 1 cycle after a CPU read issue -> no cpu_rvalid follows; tag pipeline empty after release.
- VRAM_STARVE_GUARD_EN, MAX_WAIT=15, disp_req=1 continuously, cpu_req=1 -> cpu_gnt=1 on the 16th waiting cycle; disp_drop=1 exactly one cycle; then repeats every 16 cycles.
